// File: rtl/bus_datapath.sv
// rtl/bus_datapath.sv - single-bus 32-bit datapath: 16 GPRs, PC/IR/MAR/MDR/HI/LO/Y/Z and ALU on one shared bus
// Control strobes are one-hot in intent; simultaneous strobes resolve by fixed priority.
module bus_datapath #(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      R0in,
  input  logic                      R1in,
  input  logic                      R2in,
  input  logic                      R3in,
  input  logic                      R4in,
  input  logic                      R5in,
  input  logic                      R6in,
  input  logic                      R7in,
  input  logic                      R8in,
  input  logic                      R9in,
  input  logic                      R10in,
  input  logic                      R11in,
  input  logic                      R12in,
  input  logic                      R13in,
  input  logic                      R14in,
  input  logic                      R15in,
  input  logic                      PCin,
  input  logic                      IRin,
  input  logic                      RYin,
  input  logic                      RZin,
  input  logic                      MARin,
  input  logic                      HIin,
  input  logic                      LOin,
  input  logic                      MDRin,
  input  logic                      Read,
  input  logic                      MDRout,
  input  logic                      LOout,
  input  logic                      HIout,
  input  logic                      Zhighout,
  input  logic                      Zlowout,
  input  logic                      PCout,
  input  logic                      R15out,
  input  logic                      R14out,
  input  logic                      R13out,
  input  logic                      R12out,
  input  logic                      R11out,
  input  logic                      R10out,
  input  logic                      R9out,
  input  logic                      R8out,
  input  logic                      R7out,
  input  logic                      R6out,
  input  logic                      R5out,
  input  logic                      R4out,
  input  logic                      R3out,
  input  logic                      R2out,
  input  logic                      R1out,
  input  logic                      R0out,
  input  logic                      ADD,
  input  logic                      SUB,
  input  logic                      MUL,
  input  logic                      DIV,
  input  logic                      SHR,
  input  logic                      SHL,
  input  logic                      ROR,
  input  logic                      ROL,
  input  logic                      AND,
  input  logic                      OR,
  input  logic                      NEGATE,
  input  logic                      NOT,
  input  logic [BITS-1:0]           Mdatain,
  output logic [BITS*REGISTERS-1:0] genRegisterStream
);

  logic [REGISTERS-1:0] r_in;
  logic [REGISTERS-1:0] r_out;

  logic [BITS-1:0]   gpr_q [REGISTERS];
  logic [BITS-1:0]   pc_q;
  logic [BITS-1:0]   IR;
  logic [BITS-1:0]   MAR;
  logic [BITS-1:0]   mdr_q;
  logic [BITS-1:0]   hi_q;
  logic [BITS-1:0]   lo_q;
  logic [BITS-1:0]   y_q;
  logic [2*BITS-1:0] z_q;

  logic [BITS-1:0]   bus;
  logic [BITS-1:0]   mdr_d;
  logic [2*BITS-1:0] z_d;

  logic [BITS:0]     add_s;
  logic [2*BITS-1:0] mul_p;
  logic [4:0]        sh;
  logic [5:0]        rsh;
  logic [BITS-1:0]   ror_r;
  logic [BITS-1:0]   rol_r;
  logic              div_neg_a;
  logic              div_neg_b;
  logic [BITS-1:0]   div_ua;
  logic [BITS-1:0]   div_ub;
  logic [BITS-1:0]   div_uq;
  logic [BITS-1:0]   div_ur;
  logic [BITS-1:0]   div_q;
  logic [BITS-1:0]   div_r;

  // MAR and IR have no consumers inside this block; they are observed hierarchically.
  logic unused_obs;
  assign unused_obs = ^{MAR, IR};

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  // Ascending scan lets the highest-numbered GPR win; the special registers override it.
  always_comb begin
    bus = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (r_out[i]) bus = gpr_q[i];
    end
    if (MDRout)        bus = mdr_q;
    else if (LOout)    bus = lo_q;
    else if (HIout)    bus = hi_q;
    else if (Zhighout) bus = z_q[2*BITS-1:BITS];
    else if (Zlowout)  bus = z_q[BITS-1:0];
    else if (PCout)    bus = pc_q;
  end

  assign add_s = {1'b0, y_q} + {1'b0, bus};
  assign mul_p = $signed(y_q) * $signed(bus);
  assign sh    = bus[4:0];
  assign rsh   = 6'(BITS) - {1'b0, sh};
  assign ror_r = (y_q >> sh) | (y_q << rsh);
  assign rol_r = (y_q << sh) | (y_q >> rsh);

  // Signed divide done on magnitudes so the most-negative dividend never overflows.
  always_comb begin
    div_neg_a = y_q[BITS-1];
    div_neg_b = bus[BITS-1];
    div_ua    = div_neg_a ? -y_q : y_q;
    div_ub    = div_neg_b ? -bus : bus;
    div_uq    = div_ua / div_ub;
    div_ur    = div_ua % div_ub;
    div_q     = (div_neg_a ^ div_neg_b) ? -div_uq : div_uq;
    div_r     = div_neg_a ? -div_ur : div_ur;
  end

  always_comb begin
    z_d = {{BITS{1'b0}}, bus + BITS'(1)};
    if (ADD)         z_d = {{(BITS-1){1'b0}}, add_s};
    else if (SUB)    z_d = {{BITS{1'b0}}, y_q - bus};
    else if (MUL)    z_d = mul_p;
    else if (DIV)    z_d = (bus == '0) ? {y_q, {BITS{1'b1}}} : {div_r, div_q};
    else if (SHR)    z_d = {{BITS{1'b0}}, y_q >> sh};
    else if (SHL)    z_d = {{BITS{1'b0}}, y_q << sh};
    else if (ROR)    z_d = {{BITS{1'b0}}, ror_r};
    else if (ROL)    z_d = {{BITS{1'b0}}, rol_r};
    else if (AND)    z_d = {{BITS{1'b0}}, y_q & bus};
    else if (OR)     z_d = {{BITS{1'b0}}, y_q | bus};
    else if (NEGATE) z_d = {{BITS{1'b0}}, -bus};
    else if (NOT)    z_d = {{BITS{1'b0}}, ~bus};
  end

  assign mdr_d = Read ? Mdatain : bus;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < REGISTERS; i++) gpr_q[i] <= '0;
      pc_q  <= '0;
      IR    <= '0;
      MAR   <= '0;
      mdr_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < REGISTERS; i++) begin
        if (r_in[i]) gpr_q[i] <= bus;
      end
      if (PCin)  pc_q  <= bus;
      if (IRin)  IR    <= bus;
      if (MARin) MAR   <= bus;
      if (MDRin) mdr_q <= mdr_d;
      if (HIin)  hi_q  <= bus;
      if (LOin)  lo_q  <= bus;
      if (RYin)  y_q   <= bus;
      if (RZin)  z_q   <= z_d;
    end
  end

  always_comb begin
    genRegisterStream = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      genRegisterStream[i*BITS +: BITS] = gpr_q[i];
    end
  end

endmodule

// File: tb/tb_bus_datapath.sv
// tb/tb_bus_datapath.sv - directed vector table, reset sequences and randomized micro-ops against a reference model
module tb_bus_datapath;

  logic          Clock;
  logic          Reset_n;
  logic [15:0]   rin_v;
  logic [15:0]   rout_v;
  logic [7:0]    cin_v;
  logic [5:0]    cout_v;
  logic [11:0]   op_v;
  logic          Read;
  logic [31:0]   Mdatain;
  logic [511:0]  genRegisterStream;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [7:0] PCIN = 8'h01, IRIN = 8'h02, RYIN = 8'h04, RZIN = 8'h08,
                         MARIN = 8'h10, HIIN = 8'h20, LOIN = 8'h40, MDRIN = 8'h80;
  localparam logic [5:0] MDROUT = 6'h01, LOOUT = 6'h02, HIOUT = 6'h04,
                         ZHOUT = 6'h08, ZLOUT = 6'h10, PCOUT = 6'h20;
  localparam logic [11:0] OP_ADD = 12'h001, OP_MUL = 12'h004, OP_DIV = 12'h008,
                          OP_SHR = 12'h010, OP_ROR = 12'h040, OP_ROL = 12'h080,
                          OP_AND = 12'h100, OP_NEG = 12'h400, OP_NOT = 12'h800;
  localparam int C_NONE = 0, C_GPR = 1, C_PC = 2, C_IR = 3, C_MAR = 4, C_MDR = 5,
                 C_ZLO = 6, C_ZHI = 7, C_HI = 8, C_LO = 9;

  bus_datapath dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .R0in(rin_v[0]), .R1in(rin_v[1]), .R2in(rin_v[2]), .R3in(rin_v[3]),
    .R4in(rin_v[4]), .R5in(rin_v[5]), .R6in(rin_v[6]), .R7in(rin_v[7]),
    .R8in(rin_v[8]), .R9in(rin_v[9]), .R10in(rin_v[10]), .R11in(rin_v[11]),
    .R12in(rin_v[12]), .R13in(rin_v[13]), .R14in(rin_v[14]), .R15in(rin_v[15]),
    .PCin(cin_v[0]), .IRin(cin_v[1]), .RYin(cin_v[2]), .RZin(cin_v[3]),
    .MARin(cin_v[4]), .HIin(cin_v[5]), .LOin(cin_v[6]), .MDRin(cin_v[7]),
    .Read(Read),
    .MDRout(cout_v[0]), .LOout(cout_v[1]), .HIout(cout_v[2]),
    .Zhighout(cout_v[3]), .Zlowout(cout_v[4]), .PCout(cout_v[5]),
    .R15out(rout_v[15]), .R14out(rout_v[14]), .R13out(rout_v[13]), .R12out(rout_v[12]),
    .R11out(rout_v[11]), .R10out(rout_v[10]), .R9out(rout_v[9]), .R8out(rout_v[8]),
    .R7out(rout_v[7]), .R6out(rout_v[6]), .R5out(rout_v[5]), .R4out(rout_v[4]),
    .R3out(rout_v[3]), .R2out(rout_v[2]), .R1out(rout_v[1]), .R0out(rout_v[0]),
    .ADD(op_v[0]), .SUB(op_v[1]), .MUL(op_v[2]), .DIV(op_v[3]),
    .SHR(op_v[4]), .SHL(op_v[5]), .ROR(op_v[6]), .ROL(op_v[7]),
    .AND(op_v[8]), .OR(op_v[9]), .NEGATE(op_v[10]), .NOT(op_v[11]),
    .Mdatain(Mdatain),
    .genRegisterStream(genRegisterStream)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  logic [31:0] m_gpr [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y;
  logic [63:0] m_z;

  typedef struct {
    logic [15:0] ri;
    logic [15:0] ro;
    logic [7:0]  ci;
    logic [5:0]  co;
    logic [11:0] op;
    bit          rd;
    logic [31:0] md;
    int          chk;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic vec(input logic [15:0] ri, input logic [15:0] ro, input logic [7:0] ci,
                     input logic [5:0] co, input logic [11:0] op, input bit rd,
                     input logic [31:0] md, input int chk, input int idx, input logic [31:0] exp);
    vec_t v;
    v.ri = ri; v.ro = ro; v.ci = ci; v.co = co; v.op = op; v.rd = rd; v.md = md;
    v.chk = chk; v.idx = idx; v.exp = exp;
    tbl.push_back(v);
  endtask

  function automatic logic [15:0] rb(input int n);
    return 16'h0001 << n;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_gpr[i] = '0;
    m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0;
    m_hi = '0; m_lo = '0; m_y = '0; m_z = '0;
  endtask

  function automatic logic [31:0] model_bus(input logic [5:0] co, input logic [15:0] ro);
    if (co[0]) return m_mdr;
    if (co[1]) return m_lo;
    if (co[2]) return m_hi;
    if (co[3]) return m_z[63:32];
    if (co[4]) return m_z[31:0];
    if (co[5]) return m_pc;
    for (int i = 15; i >= 0; i--) if (ro[i]) return m_gpr[i];
    return '0;
  endfunction

  function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                             input logic [11:0] op);
    int sel = -1;
    int s;
    longint sa, sb, q, r;
    logic [31:0] rot;
    for (int i = 0; i < 12; i++) if (op[i] && sel < 0) sel = i;
    sa = $signed(a);
    sb = $signed(b);
    s  = int'(b[4:0]);
    case (sel)
      0:  return {32'd0, a} + {32'd0, b};
      1:  return {32'd0, a - b};
      2:  return sa * sb;
      3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4:  return {32'd0, a >> s};
      5:  return {32'd0, a << s};
      6: begin
        rot = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
        return {32'd0, rot};
      end
      7: begin
        rot = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
        return {32'd0, rot};
      end
      8:  return {32'd0, a & b};
      9:  return {32'd0, a | b};
      10: return {32'd0, 32'd0 - b};
      11: return {32'd0, ~b};
      default: return {32'd0, b + 32'd1};
    endcase
  endfunction

  task automatic clear_inputs();
    rin_v = '0; rout_v = '0; cin_v = '0; cout_v = '0; op_v = '0;
    Read = 1'b0; Mdatain = '0;
  endtask

  task automatic apply(input logic [15:0] ri, input logic [15:0] ro, input logic [7:0] ci,
                       input logic [5:0] co, input logic [11:0] op, input bit rd,
                       input logic [31:0] md, input bit chk_bus);
    logic [31:0] b;
    logic [63:0] r;
    rin_v = ri; rout_v = ro; cin_v = ci; cout_v = co; op_v = op; Read = rd; Mdatain = md;
    #1;
    b = model_bus(co, ro);
    r = model_alu(m_y, b, op);
    if (chk_bus) check("bus", 64'(dut.bus), 64'(b));
    @(posedge Clock);
    for (int i = 0; i < 16; i++) if (ri[i]) m_gpr[i] = b;
    if (ci[0]) m_pc  = b;
    if (ci[1]) m_ir  = b;
    if (ci[2]) m_y   = b;
    if (ci[3]) m_z   = r;
    if (ci[4]) m_mar = b;
    if (ci[5]) m_hi  = b;
    if (ci[6]) m_lo  = b;
    if (ci[7]) m_mdr = rd ? md : b;
    #1;
    clear_inputs();
  endtask

  function automatic logic [31:0] probe(input int chk, input int idx);
    case (chk)
      C_GPR:   return genRegisterStream[idx*32 +: 32];
      C_PC:    return dut.pc_q;
      C_IR:    return dut.IR;
      C_MAR:   return dut.MAR;
      C_MDR:   return dut.mdr_q;
      C_ZLO:   return dut.z_q[31:0];
      C_ZHI:   return dut.z_q[63:32];
      C_HI:    return dut.hi_q;
      C_LO:    return dut.lo_q;
      default: return '0;
    endcase
  endfunction

  task automatic check_all_vs_model();
    for (int i = 0; i < 16; i++)
      check($sformatf("r%0d", i), 64'(genRegisterStream[i*32 +: 32]), 64'(m_gpr[i]));
    check("pc",  64'(dut.pc_q),  64'(m_pc));
    check("ir",  64'(dut.IR),    64'(m_ir));
    check("mar", 64'(dut.MAR),   64'(m_mar));
    check("mdr", 64'(dut.mdr_q), 64'(m_mdr));
    check("hi",  64'(dut.hi_q),  64'(m_hi));
    check("lo",  64'(dut.lo_q),  64'(m_lo));
    check("y",   64'(dut.y_q),   64'(m_y));
    check("z",   dut.z_q,        m_z);
  endtask

  task automatic load_gpr(input int n, input logic [31:0] val);
    vec(0, 0, MDRIN, 0, 0, 1, val, C_NONE, 0, 0);
    vec(rb(n), 0, 0, MDROUT, 0, 0, 0, C_GPR, n, val);
  endtask

  logic [31:0] specials [6];

  initial begin
    clear_inputs();
    Reset_n = 1'b0;
    model_reset();
    specials[0] = 32'h0; specials[1] = 32'h8000_0000; specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h1; specials[4] = 32'h7FFF_FFFF; specials[5] = 32'h20;

    vec(0, 0, MDRIN, 0, 0, 1, 32'h22, C_MDR, 0, 32'h22);
    vec(rb(2), 0, 0, MDROUT, 0, 0, 0, C_GPR, 2, 32'h22);
    load_gpr(4, 32'h24);
    load_gpr(5, 32'h26);
    vec(0, 0, MARIN | RZIN, PCOUT, 0, 0, 0, C_MAR, 0, 32'h0);
    vec(0, 0, 0, 0, 0, 0, 0, C_ZLO, 0, 32'h1);
    vec(0, 0, PCIN | MDRIN, ZLOUT, 0, 1, 32'h4A92_0000, C_PC, 0, 32'h1);
    vec(0, 0, 0, 0, 0, 0, 0, C_MDR, 0, 32'h4A92_0000);
    vec(0, 0, IRIN, MDROUT, 0, 0, 0, C_IR, 0, 32'h4A92_0000);
    vec(0, rb(2), RYIN, 0, 0, 0, 0, C_NONE, 0, 0);
    vec(0, rb(4), RZIN, 0, OP_AND, 0, 0, C_ZLO, 0, 32'h20);
    vec(rb(5), 0, 0, ZLOUT, 0, 0, 0, C_GPR, 5, 32'h20);
    load_gpr(2, 32'hFFFF_FFFE);
    load_gpr(4, 32'h3);
    vec(0, rb(2), RYIN, 0, 0, 0, 0, C_NONE, 0, 0);
    vec(0, rb(4), RZIN, 0, OP_MUL, 0, 0, C_ZLO, 0, 32'hFFFF_FFFA);
    vec(0, 0, LOIN, ZLOUT, 0, 0, 0, C_LO, 0, 32'hFFFF_FFFA);
    vec(0, 0, HIIN, ZHOUT, 0, 0, 0, C_HI, 0, 32'hFFFF_FFFF);
    load_gpr(2, 32'h7);
    load_gpr(4, 32'h2);
    vec(0, rb(2), RYIN, 0, 0, 0, 0, C_NONE, 0, 0);
    vec(0, rb(4), RZIN, 0, OP_DIV, 0, 0, C_ZLO, 0, 32'h3);
    vec(0, 0, 0, 0, 0, 0, 0, C_ZHI, 0, 32'h1);
    load_gpr(4, 32'h0);
    vec(0, rb(4), RZIN, 0, OP_DIV, 0, 0, C_ZLO, 0, 32'hFFFF_FFFF);
    vec(0, 0, 0, 0, 0, 0, 0, C_ZHI, 0, 32'h7);
    load_gpr(2, 32'h8000_0001);
    vec(0, rb(2), RYIN, 0, 0, 0, 0, C_NONE, 0, 0);
    load_gpr(4, 32'h1);
    vec(0, rb(4), RZIN, 0, OP_ROR, 0, 0, C_ZLO, 0, 32'hC000_0000);
    vec(0, rb(4), RZIN, 0, OP_SHR, 0, 0, C_ZLO, 0, 32'h4000_0000);
    vec(0, rb(4), RZIN, 0, OP_ROL, 0, 0, C_ZLO, 0, 32'h0000_0003);
    vec(0, rb(4), RZIN, 0, OP_NEG, 0, 0, C_ZLO, 0, 32'hFFFF_FFFF);
    vec(0, 0, 0, 0, 0, 0, 0, C_ZHI, 0, 32'h0);
    vec(rb(6), rb(2), 0, MDROUT, 0, 0, 0, C_GPR, 6, 32'h1);
    vec(0, rb(4), RZIN, 0, OP_ADD | OP_NOT, 0, 0, C_ZLO, 0, 32'h8000_0002);
    vec(0, rb(2), RZIN, 0, OP_ADD, 0, 0, C_ZLO, 0, 32'h2);
    vec(0, 0, 0, 0, 0, 0, 0, C_ZHI, 0, 32'h1);
    vec(rb(2), rb(2), 0, 0, 0, 0, 0, C_GPR, 2, 32'h8000_0001);
    vec(0, 0, RZIN, PCOUT, 0, 0, 0, C_ZLO, 0, 32'h2);

    #3;
    check("reset_stream", 64'(genRegisterStream == '0), 64'(1));
    check("reset_z", dut.z_q, 64'h0);
    #9 Reset_n = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].ri, tbl[i].ro, tbl[i].ci, tbl[i].co, tbl[i].op, tbl[i].rd, tbl[i].md, 1'b0);
      if (tbl[i].chk != C_NONE)
        check($sformatf("vec%0d", i), 64'(probe(tbl[i].chk, tbl[i].idx)), 64'(tbl[i].exp));
    end
    check_all_vs_model();

    // Asynchronous reset mid-cycle, then held across an edge with loads requested.
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_stream", 64'(genRegisterStream == '0), 64'(1));
    check("async_rst_pc", 64'(dut.pc_q), 64'h0);
    check("async_rst_ir", 64'(dut.IR), 64'h0);
    check("async_rst_z", dut.z_q, 64'h0);
    cin_v = 8'hFF; rin_v = 16'hFFFF; Read = 1'b1; Mdatain = 32'hDEAD_BEEF; op_v = OP_ADD;
    @(posedge Clock);
    #1;
    check("rst_hold_mdr", 64'(dut.mdr_q), 64'h0);
    check("rst_hold_stream", 64'(genRegisterStream == '0), 64'(1));
    clear_inputs();
    model_reset();
    #2 Reset_n = 1'b1;

    for (int it = 0; it < 300; it++) begin
      logic [15:0] ri, ro;
      logic [7:0]  ci;
      logic [5:0]  co;
      logic [11:0] op;
      logic [31:0] md;
      int k;
      k = $urandom_range(0, 3);
      ro = (k == 0) ? 16'h0 : (k == 1) ? rb($urandom_range(0, 15)) :
           (k == 2) ? (rb($urandom_range(0, 15)) | rb($urandom_range(0, 15))) : 16'($urandom);
      co = '0;
      for (int j = 0; j < 6; j++) co[j] = ($urandom_range(0, 7) == 0);
      ri = 16'($urandom & $urandom & $urandom);
      ci = 8'($urandom & $urandom);
      if ($urandom_range(0, 2) == 0) ci[7] = 1'b1;
      k = $urandom_range(0, 3);
      op = (k == 0) ? 12'h0 : (k == 3) ? 12'($urandom) : (12'h1 << $urandom_range(0, 11));
      md = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      apply(ri, ro, ci, co, op, 1'($urandom_range(0, 1)), md, 1'b1);
      check_all_vs_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_datapath.md
Name: bus_datapath

Overview:
- Single-bus, 32-bit CPU datapath for a 16-register processor.
- Contains R0–R15, PC, IR, MAR, MDR, HI, LO, Y, a 64-bit Z register and an ALU, all joined by one shared 32-bit bus.
- An external control unit or testbench drives one-hot register-out, register-in and ALU-operation strobes.
- All general-register contents are exported as one flat stream for observation.

Parameters:
BITS, 32, datapath word width; only 32 is supported
REGISTERS, 16, number of general registers; genRegisterStream width is BITS*REGISTERS

Ports:
Clock  in  1  system clock; all register loads occur on its rising edge
Reset_n  in  1  asynchronous active-low reset; clears every register
R0in..R15in  in  1 each  load the bus into general register Rn
PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin  in  1 each  register load enables; RYin loads Y, RZin loads Z
Read  in  1  MDR source select: 1 = Mdatain, 0 = bus
MDRout, LOout, HIout, Zhighout, Zlowout, PCout  in  1 each  drive that register onto the bus
R15out..R0out  in  1 each  drive general register Rn onto the bus
ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT  in  1 each  ALU operation select
Mdatain  in  32  memory read data
genRegisterStream  out  512  {R15,...,R0}; R0 occupies bits [31:0]

Port order:
- Reset_n comes directly after Clock.
- All remaining ports follow in the order listed above.

Behaviour:
- Reset: while Reset_n = 0, every register (R0–R15, PC, IR, MAR, MDR, HI, LO, Y, Z) is 0, so genRegisterStream = 0. Reset is asynchronous and overrides any load in flight.
- Bus:
  - Combinational mux.
  - No out-strobe asserted: bus = 0.
  - Several strobes asserted: priority is MDRout > LOout > HIout > Zhighout > Zlowout > PCout > R15out > … > R0out.
  - Zhighout drives Z[63:32]; Zlowout drives Z[31:0].
- Register loads: on the rising Clock edge each enabled register captures its input, visible from that edge onward. Zero-cycle latency from bus to capture.
- Register inputs:
  - MDR captures (Read ? Mdatain : bus).
  - Z captures the 64-bit ALU result.
  - All other registers capture the bus.
  - R0 is an ordinary register.
  - MAR and IR have no outputs besides internal storage. Their values are hierarchically visible to verification as MAR and IR.
- ALU, combinational: A = Y, B = bus. Result R is 64 bits.
  - ADD: R[31:0] = A+B; R[63:32] = carry-out in bit 32, upper bits 0.
  - SUB: R[31:0] = A−B; R[63:32] = 0.
  - MUL: R = signed A × signed B (full 64-bit product).
  - DIV: R[31:0] = signed A/B quotient; R[63:32] = remainder.
    - Quotient truncates toward zero.
    - Remainder takes the sign of the dividend.
    - B = 0: quotient = 0xFFFFFFFF, remainder = A.
  - SHR: A >> B[4:0], logical.
  - SHL: A << B[4:0].
  - ROR and ROL: rotate A by B[4:0].
  - AND: A & B. OR: A | B.
  - NEGATE: −B (two's complement). NOT: ~B.
  - Every result except MUL, DIV and ADD has R[63:32] = 0.
  - No operation selected: R = B + 1 (PC increment path, used with PCout+RZin and then Zlowout+PCin).
  - Several operations selected: priority follows port order, ADD highest, NOT lowest.
- Simultaneous bus drive and load of the same register, e.g. R2out+R2in: the register reloads its own value.

Test Plan:
- Reset: assert Reset_n=0 mid-run after registers hold data -> all registers and genRegisterStream read 0 immediately, without waiting for a clock edge.
- Register load: Mdatain=0x22, Read=MDRin=1 for one edge; then MDRout=R2in=1 for one edge -> R2 = 0x22 and genRegisterStream[95:64] = 0x22. Repeat with 0x24 into R4 and 0x26 into R5.
- Fetch:
  - PC=0, then PCout=MARin=RZin=1 -> MAR = 0 and Z = 1.
  - Then Zlowout=PCin=1 together with Read=MDRin=1, Mdatain=0x4A920000 -> PC = 1 and MDR = 0x4A920000.
  - Then MDRout=IRin=1 -> IR = 0x4A920000.
- AND: R2=0x22, R4=0x24. Sequence R2out+RYin, then R4out+AND+RZin, then Zlowout+R5in -> R5 = 0x20, replacing 0x26.
- MUL/DIV, each via Y=R2 and bus=R4:
  - MUL with Y=0xFFFFFFFE (−2), bus=3; then Zlowout+LOin, Zhighout+HIin -> LO = 0xFFFFFFFA, HI = 0xFFFFFFFF.
  - DIV with Y=7, bus=2 -> Zlow = 3, Zhigh = 1.
  - DIV with bus=0 -> Zlow = 0xFFFFFFFF, Zhigh = 7.
- Shift/unary and bus priority:
  - Y=0x80000001, bus=1: ROR -> 0xC0000000, SHR -> 0x40000000.
  - NEGATE with bus=1 -> 0xFFFFFFFF.
  - MDRout and R2out asserted together -> bus carries MDR.
